bch1572_serial_encoder: RTL and testbench
=========================================

BCH1572_SERIAL_ENCODER -- requirements
Module: bch1572_serial_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the word_count output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, 7 bits: message word; bit 6 is transmitted first.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the encoder accepts a word this cycle.
REQ-007 SHALL have port ser_bit, output, 1 bit: the current serial codeword bit.
REQ-008 SHALL have port ser_valid, output, 1 bit: ser_bit is valid.
REQ-009 SHALL have port ser_ready, input, 1 bit: downstream consumes ser_bit this cycle.
REQ-010 SHALL have port ser_sof, output, 1 bit: high while codeword bit 14 (the first bit) is presented.
REQ-011 SHALL have port ser_eof, output, 1 bit: high while codeword bit 0 (the last bit) is presented.
REQ-012 SHALL have port word_count, output, CNT_W bits: number of codewords fully transmitted, mod 2^CNT_W.

Function
REQ-013 SHALL produce a systematic BCH(15,7,2) codeword {m[6:0], p[7:0]}.
- Generator polynomial: g(x) = x^8+x^7+x^6+x^4+1.
- Parity: p(x) = m(x)·x^8 mod g(x).
- Transmission order: MSB first (codeword bit 14 first).
REQ-014 SHALL implement a state machine with three states.
- IDLE: no word in flight.
- DATA: bit counter 0..6.
- PARITY: bit counter 7..14.
REQ-015 SHALL capture a word on a handshake (in_valid && in_ready at a rising edge).
- Captures in_data, clears the parity LFSR to 0, sets the bit counter to 0, enters DATA.
- ser_valid goes high in the next cycle with ser_bit = in_data[6].
REQ-016 SHALL define a bit transfer as ser_valid && ser_ready at a rising edge; ser_bit and the counter SHALL advance only on a transfer, and SHALL hold all values while ser_ready is low.
REQ-017 SHALL update the parity LFSR on each DATA transfer of bit d.
- fb = d ^ p[7].
- p = {p[6:0],0} ^ (fb ? 8'hD1 : 8'h00).
REQ-018 SHALL present ser_bit = p[7] in PARITY, and shift p left with zero fill on each PARITY transfer.
REQ-019 SHALL move from DATA to PARITY on the transfer of counter value 6.
REQ-020 SHALL end a codeword on the transfer of counter value 14.
- Increments word_count, wrapping from 2^CNT_W-1 to 0.
- Returns to IDLE, or loads the next word directly if a handshake occurs in the same cycle (REQ-021).
REQ-021 SHALL drive in_ready = 1 in IDLE, and in PARITY when counter = 14 and ser_ready = 1; in_ready SHALL be 0 otherwise. This allows back-to-back codewords at 15 transfers per word with no gap.
REQ-022 SHALL keep ser_valid = 0 in IDLE and ser_valid = 1 in DATA and PARITY.
REQ-023 SHALL gate ser_sof = (counter = 0) and ser_eof = (counter = 14) with ser_valid.
REQ-024 SHALL have zero combinational paths from in_valid or in_data to any ser_* output; in_ready MAY depend combinationally on ser_ready.
REQ-025 SHALL ignore in_data while in_ready = 0, and SHALL not corrupt the in-flight word.

Reset
REQ-026 SHALL, while rst_n = 0, asynchronously force: state IDLE, counter 0, LFSR 0, data register 0, word_count 0.
REQ-027 SHALL drive these outputs during reset: ser_valid = 0, ser_bit = 0, ser_sof = 0, ser_eof = 0.
REQ-028 SHALL drive in_ready = 0 while rst_n = 0, and in_ready = 1 from the first clock edge after rst_n deasserts.
REQ-029 SHALL discard a partial codeword when reset occurs mid-word; the partial word SHALL not be resumed or counted.

Verification
REQ-030 Encode in_data = 7'h01 with ser_ready = 1 -> serial stream 000000111010001 over 15 cycles; sof on the first bit, eof on the last; word_count = 1.
REQ-031 Encode in_data = 7'h40 -> stream 100000011101000 (parity 8'hE8); encode 7'h00 -> 15 zero bits.
REQ-032 Back-to-back: in_valid held high with words 7'h5B then 7'h2A -> 30 contiguous valid bits, no gap; in_ready pulses exactly on the eof transfer; word_count = 2.
REQ-033 Backpressure: toggle ser_ready pseudo-randomly -> bit sequence identical to REQ-030; outputs stable while ser_ready = 0; in_ready = 0 mid-word even with in_valid = 1.
REQ-034 Reset asserted after 9 transfers -> ser_valid = 0 immediately; word_count = 0; the next word encodes correctly from bit 14.
REQ-035 Exhaustive: all 128 messages checked -> each codeword is divisible by g(x) (zero remainder); with CNT_W = 7, word_count wraps to 0 after 128 words.

Source files
------------

// File: rtl/bch1572_serial_encoder.sv
// Serial BCH(15,7) encoder: captures a 7-bit message and emits {msg, parity} MSB first, one bit per ser transfer.
// Latency: first bit valid the cycle after capture; back-to-back words with no gap. Backpressure: ser_ready low freezes all state.
module bch1572_serial_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_sof,
    output logic             ser_eof,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [6:0]       msg_q, msg_d;
    logic [7:0]       par_q, par_d;
    logic [CNT_W-1:0] wc_q, wc_d;
    logic             live_q;
    logic             xfer;
    logic             hs;
    logic             fb;

    assign ser_valid  = (state_q != S_IDLE);
    assign ser_bit    = (state_q == S_DATA)   ? msg_q[6] :
                        (state_q == S_PARITY) ? par_q[7] : 1'b0;
    assign ser_sof    = ser_valid && (cnt_q == 4'd0);
    assign ser_eof    = ser_valid && (cnt_q == 4'd14);
    assign word_count = wc_q;

    // live_q keeps in_ready low until the first edge after reset release
    assign in_ready = live_q && ((state_q == S_IDLE) ||
                      ((state_q == S_PARITY) && (cnt_q == 4'd14) && ser_ready));

    assign xfer = ser_valid && ser_ready;
    assign hs   = in_valid && in_ready;
    assign fb   = msg_q[6] ^ par_q[7];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        par_d   = par_q;
        wc_d    = wc_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    msg_d   = in_data;
                    par_d   = 8'h00;
                    cnt_d   = 4'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    par_d = {par_q[6:0], 1'b0} ^ (fb ? 8'hD1 : 8'h00);
                    msg_d = {msg_q[5:0], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd6) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (xfer) begin
                    par_d = {par_q[6:0], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd14) begin
                        wc_d    = wc_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                        if (hs) begin
                            msg_d   = in_data;
                            par_d   = 8'h00;
                            state_d = S_DATA;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            msg_q   <= 7'd0;
            par_q   <= 8'd0;
            wc_q    <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            par_q   <= par_d;
            wc_q    <= wc_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bch1572_serial_encoder.sv
// Directed bench for bch1572_serial_encoder: table of hand-computed codewords plus
// back-to-back, backpressure, mid-word reset and all-messages divisibility sequences.
module tb_bch1572_serial_encoder;

    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ser_bit;
    logic             ser_valid;
    logic             ser_ready = 1'b1;
    logic             ser_sof;
    logic             ser_eof;
    logic [CNT_W-1:0] word_count;

    bch1572_serial_encoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_sof    (ser_sof),
        .ser_eof    (ser_eof),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] msg;
        logic [7:0] par;
    } vec_t;

    vec_t        tbl[6];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [6:0]  exp_wc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Long division of a 15-bit codeword by g(x) = 0x1D1
    function automatic logic [7:0] rem15(input logic [14:0] cw);
        logic [14:0] r;
        logic [14:0] g;
        r = cw;
        g = 15'h01D1;
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (g << (i - 8));
        end
        return r[7:0];
    endfunction

    // Called at a negedge with the encoder idle; returns at the negedge after the capture edge.
    task automatic start_word(input logic [6:0] m);
        int w;
        in_data   = m;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    // Collects n transfers (left-aligned in got), checking flags, in_ready and stall stability.
    task automatic collect(input int n, input bit bp, input bit hold,
                           input logic [29:0] exp, output logic [29:0] got, output int err);
        int k;
        int cyc;
        int pos;
        k   = 0;
        cyc = 0;
        err = 0;
        got = '0;
        while (k < n && cyc < 600) begin
            ser_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = hold && (k < n - 1);
            #1;
            pos = k % 15;
            if (!ser_valid) err++;
            else begin
                if (ser_sof !== (pos == 0) || ser_eof !== (pos == 14)) err++;
                if (in_ready !== (ser_ready && pos == 14)) err++;
                if (ser_ready) begin
                    got[29 - k] = ser_bit;
                    k++;
                end else if (ser_bit !== exp[29 - k]) err++;
            end
            cyc++;
            @(negedge clk);
        end
        if (k < n) err += 1000;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
    endtask

    initial begin
        logic [29:0] exp;
        logic [29:0] got;
        int          err;
        int          bad;

        tbl[0] = '{7'h01, 8'hD1};
        tbl[1] = '{7'h40, 8'hE8};
        tbl[2] = '{7'h00, 8'h00};
        tbl[3] = '{7'h5B, 8'h6D};
        tbl[4] = '{7'h2A, 8'h1A};
        tbl[5] = '{7'h7F, 8'hFF};

        // Reset state
        #12;
        check("rst_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_ser_bit",   32'(ser_bit),   32'd0);
        check("rst_sof_eof",   32'({ser_sof, ser_eof}), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("in_ready_after_edge", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Table-driven single words at full rate
        for (int i = 0; i < 6; i++) begin
            exp = {tbl[i].msg, tbl[i].par, 15'd0};
            start_word(tbl[i].msg);
            collect(15, 1'b0, 1'b0, exp, got, err);
            exp_wc++;
            check($sformatf("stream_%0h", tbl[i].msg), 32'(got[29:15]), 32'(exp[29:15]));
            check($sformatf("flags_%0h", tbl[i].msg), 32'(err), 32'd0);
            check($sformatf("wc_%0h", tbl[i].msg), 32'(word_count), 32'(exp_wc));
            #1;
            check($sformatf("idle_%0h", tbl[i].msg), 32'(ser_valid), 32'd0);
            @(negedge clk);
        end

        // Back-to-back: 5B then 2A with in_valid held
        exp = {7'h5B, 8'h6D, 7'h2A, 8'h1A};
        start_word(7'h5B);
        in_data = 7'h2A;
        collect(30, 1'b0, 1'b1, exp, got, err);
        exp_wc = exp_wc + 7'd2;
        check("b2b_stream", 32'(got), 32'(exp));
        check("b2b_flags", 32'(err), 32'd0);
        check("b2b_wc", 32'(word_count), 32'(exp_wc));

        // Backpressure with junk data held valid mid-word
        @(negedge clk);
        exp = {7'h01, 8'hD1, 15'd0};
        start_word(7'h01);
        in_data = 7'h7E;
        collect(15, 1'b1, 1'b1, exp, got, err);
        exp_wc++;
        check("bp_stream", 32'(got[29:15]), 32'(exp[29:15]));
        check("bp_flags", 32'(err), 32'd0);
        check("bp_wc", 32'(word_count), 32'(exp_wc));

        // Reset after 9 transfers
        @(negedge clk);
        start_word(7'h01);
        collect(9, 1'b0, 1'b0, exp, got, err);
        check("pre_reset_stream", 32'(got[29:21]), 32'(exp[29:21]));
        rst_n = 1'b0;
        #1;
        check("midrst_ser_valid", 32'(ser_valid), 32'd0);
        check("midrst_wc", 32'(word_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp = {7'h40, 8'hE8, 15'd0};
        start_word(7'h40);
        collect(15, 1'b0, 1'b0, exp, got, err);
        check("post_reset_stream", 32'(got[29:15]), 32'(exp[29:15]));
        check("post_reset_flags", 32'(err), 32'd0);
        check("post_reset_wc", 32'(word_count), 32'd1);

        // All 128 messages: codeword divisible by g(x), word_count wraps
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int m = 0; m < 128; m++) begin
            start_word(7'(m));
            collect(15, 1'b0, 1'b0, 30'd0, got, err);
            if (rem15(got[29:15]) != 8'h00 || got[29:23] != 7'(m) || err != 0) bad++;
            if (m == 126) check("wc_127", 32'(word_count), 32'd127);
        end
        check("all_divisible", 32'(bad), 32'd0);
        check("wc_wrap", 32'(word_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
